// File: rtl/dsm_pkg.sv
// Shared types, defaults and helpers for the dsm2_mod second-order delta-sigma modulator.
package dsm_pkg;

    localparam int IN_W_DEF  = 10;
    localparam int ACC_W_DEF = 16;

    // Wide enough to carry any pre-saturation sum for accumulators up to 32 bits.
    localparam int SAT_W = 34;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    // Fibonacci LFSR: taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic signed [SAT_W-1:0] val;
        logic                    clamp;
    } sat_t;

    function automatic int fb_mag(input int in_w);
        return 1 << (in_w - 1);
    endfunction

    function automatic sat_t sat_acc(input logic signed [SAT_W-1:0] v, input int acc_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t                    r;
        hi = (SAT_W'(1) << (acc_w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            r.val   = hi;
            r.clamp = 1'b1;
        end else if (v < lo) begin
            r.val   = lo;
            r.clamp = 1'b1;
        end else begin
            r.val   = v;
            r.clamp = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsm2_mod_if.sv
// Sample stream from the NCO into the modulator: strobe plus signed sample.
interface dsm2_mod_if #(
    parameter int IN_W = 10
) ();

    logic                   in_valid;
    logic signed [IN_W-1:0] in_data;

    modport master (output in_valid, output in_data);
    modport slave  (input  in_valid, input  in_data);

endinterface

// File: rtl/dsm_integ.sv
// Saturating accumulator: q_next = sat(q + add_a + add_b), registered when en is high.
module dsm_integ
    import dsm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] add_a,
    input  logic signed [ACC_W-1:0] add_b,
    output logic signed [ACC_W-1:0] q,
    output logic signed [ACC_W-1:0] q_next,
    output logic                    clamp
);

    logic signed [ACC_W:0] sum;
    sat_t                  sat_r;
    logic                  unused_hi;

    always_comb begin
        sum    = {q[ACC_W-1], q} + {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b};
        sat_r  = sat_acc({{(SAT_W-ACC_W-1){sum[ACC_W]}}, sum}, ACC_W);
        q_next = sat_r.val[ACC_W-1:0];
        clamp  = sat_r.clamp;
    end

    // Clamped value always fits ACC_W; the upper bits are pure sign extension.
    assign unused_hi = ^sat_r.val[SAT_W-1:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/dsm2_mod.sv
// Second-order single-bit delta-sigma modulator with saturating integrators and sticky overflow.
// Optional quantizer dither from a 16-bit LFSR when DSM2_DITHER_EN is defined.
module dsm2_mod
    import dsm_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FB_MAG = fb_mag(IN_W)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    dsm2_mod_if.slave in_if,
    input  logic      ovf_clr,
    output logic      dout,
    output logic      dout_n,
    output logic      ovf
);

    localparam logic signed [ACC_W-1:0] FB_POS = ACC_W'(FB_MAG);
    localparam logic signed [ACC_W-1:0] FB_NEG = -FB_POS;

    logic signed [IN_W-1:0]  x_reg;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] fb_neg;
    logic signed [ACC_W-1:0] i1;
    logic signed [ACC_W-1:0] i1n;
    logic signed [ACC_W-1:0] i2;
    logic signed [ACC_W-1:0] i2n;
    logic                    clamp1;
    logic                    clamp2;
    logic                    decide;
    logic                    unused_i1;

    // Capture is independent of en so the NCO can load a sample while stepping is paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
        end else if (in_if.in_valid) begin
            x_reg <= in_if.in_data;
        end
    end

    always_comb begin
        x_ext  = {{(ACC_W-IN_W){x_reg[IN_W-1]}}, x_reg};
        fb_neg = dout ? FB_NEG : FB_POS;
    end

    dsm_integ #(.ACC_W(ACC_W)) u_i1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .add_a  (x_ext),
        .add_b  (fb_neg),
        .q      (i1),
        .q_next (i1n),
        .clamp  (clamp1)
    );

    // Second stage takes the first stage's new value, so there is no extra loop delay.
    dsm_integ #(.ACC_W(ACC_W)) u_i2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .add_a  (i1n),
        .add_b  (fb_neg),
        .q      (i2),
        .q_next (i2n),
        .clamp  (clamp2)
    );

    assign unused_i1 = ^i1;

`ifdef DSM2_DITHER_EN
    logic [15:0]           lfsr;
    logic signed [ACC_W:0] dsum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (en) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    always_comb begin
        dsum   = {i2n[ACC_W-1], i2n} + {{(ACC_W-3){lfsr[3]}}, lfsr[3:0]};
        decide = ~dsum[ACC_W];
    end
`else
    always_comb begin
        decide = ~i2n[ACC_W-1];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= 1'b0;
            dout_n <= 1'b1;
        end else if (en) begin
            dout   <= decide;
            dout_n <= ~decide;
        end
    end

    // A clamp on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (en && (clamp1 || clamp2)) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsm2_mod.sv
// Self-checking bench for dsm2_mod: vector table, hand sequences and a random run against an arithmetic model.
module tb_dsm2_mod;

    localparam int FB   = 512;
    localparam int AMAX = 32767;
    localparam int AMIN = -32768;

    typedef struct {
        logic vld;
        int   data;
        logic en;
        logic clr;
        logic exp_dout;
        logic exp_ovf;
    } vec_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b0;
    logic ovf_clr  = 1'b0;
    logic dout;
    logic dout_n;
    logic ovf;
    logic en_b     = 1'b0;
    logic clr_b    = 1'b0;
    logic dout_b;
    logic dout_n_b;
    logic ovf_b;

    dsm2_mod_if #(.IN_W(10)) if_a ();
    dsm2_mod_if #(.IN_W(10)) if_b ();

    dsm2_mod #(.IN_W(10), .ACC_W(16)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in_if   (if_a),
        .ovf_clr (ovf_clr),
        .dout    (dout),
        .dout_n  (dout_n),
        .ovf     (ovf)
    );

    dsm2_mod #(.IN_W(10), .ACC_W(11)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en_b),
        .in_if   (if_b),
        .ovf_clr (clr_b),
        .dout    (dout_b),
        .dout_n  (dout_n_b),
        .ovf     (ovf_b)
    );

    always #50 clk = ~clk;

    vec_t ztab [14];
    int   nvec  = 0;
    int   nfail = 0;
    int   ones  = 0;
    int   m_x, m_i1, m_i2;
    logic m_dout, m_ovf;

    function automatic void chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void chk_rng(input string name, input int act, input int lo, input int hi);
        nvec++;
        if (act < lo || act > hi) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    function automatic int clampi(input int v, output logic c);
        c = 1'b0;
        if (v > AMAX) begin
            c = 1'b1;
            return AMAX;
        end
        if (v < AMIN) begin
            c = 1'b1;
            return AMIN;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_x = 0; m_i1 = 0; m_i2 = 0; m_dout = 1'b0; m_ovf = 1'b0;
    endtask

    // One clock edge of dut_a: the model advances from the inputs present before the edge.
    task automatic tick();
        logic v, e, clr, c1, c2;
        int   dv, fb, a, b;
        v = if_a.in_valid; dv = if_a.in_data; e = en; clr = ovf_clr;
        c1 = 1'b0; c2 = 1'b0;
        @(posedge clk);
        if (e) begin
            fb     = m_dout ? FB : -FB;
            a      = clampi(m_i1 + m_x - fb, c1);
            b      = clampi(m_i2 + a - fb, c2);
            m_i1   = a;
            m_i2   = b;
            m_dout = (b >= 0);
        end
        if (e && (c1 || c2)) m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
        if (v) m_x = dv;
        #1;
        if (e && dout) ones++;
        chk("dout", dout, m_dout);
        chk("dout_n", dout_n, !m_dout);
        chk("ovf", ovf, m_ovf);
        chk("i1", dut_a.u_i1.q, m_i1);
        chk("i2", dut_a.u_i2.q, m_i2);
    endtask

    task automatic run_zero_table(input string tag);
        for (int i = 0; i < 14; i++) begin
            if_a.in_valid = ztab[i].vld;
            if_a.in_data  = ztab[i].data[9:0];
            en            = ztab[i].en;
            ovf_clr       = ztab[i].clr;
            tick();
            chk({tag, "_seq_dout"}, dout, ztab[i].exp_dout);
            chk({tag, "_seq_ovf"}, ovf, ztab[i].exp_ovf);
        end
        if_a.in_valid = 1'b0;
    endtask

    // One sine period; with boxcar set, each 256-step window's input sum is compared to the DAC sum.
    task automatic run_sine(input real amp, input int x_start, input logic boxcar);
        int   x_last, x_new, sx, sf, mx, phase, ax;
        logic dprev, okw1, okw2;
        x_last = x_start; sx = 0; sf = 0; mx = 0; okw1 = 1'b0; okw2 = 1'b0;
        phase  = int'($urandom_range(0, 9999));
        for (int n = 0; n < 10000; n++) begin
            x_new = int'(amp * $sin(6.283185307179586 * real'(n + phase) / 10000.0));
            if_a.in_valid = 1'b1;
            if_a.in_data  = x_new[9:0];
            en            = 1'b1;
            dprev         = dout;
            tick();
            sx += x_last;
            sf += dprev ? FB : -FB;
            ax = (x_last < 0) ? -x_last : x_last;
            if (ax > mx) mx = ax;
            x_last = x_new;
            if ((n % 256) == 255) begin
                if (boxcar && okw1 && okw2 && mx <= 409)
                    chk_rng("boxcar_track", sx - sf, -3932, 3932);
                okw2 = okw1;
                okw1 = (mx <= 409);
                sx = 0; sf = 0; mx = 0;
            end
        end
        if_a.in_valid = 1'b0;
    endtask

    initial begin
        logic [0:13] zpat;
        int          i1_pre, fb_pre;
        logic        d_pre;

        zpat = 14'b11010011001100;
        for (int i = 0; i < 14; i++) begin
            ztab[i].vld      = (i == 0);
            ztab[i].data     = 0;
            ztab[i].en       = 1'b1;
            ztab[i].clr      = 1'b0;
            ztab[i].exp_dout = zpat[i];
            ztab[i].exp_ovf  = 1'b0;
        end

        if_a.in_valid = 1'b0; if_a.in_data = '0;
        if_b.in_valid = 1'b0; if_b.in_data = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_n", dout_n, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_i2", dut_a.u_i2.q, 0);
        chk("rst_b_dout_n", dout_n_b, 1);
        chk("rst_b_ovf", ovf_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ACC_W=11: first zero-input step drives i2n to 1024, which clamps.
        en_b = 1'b1;
        tick();
        chk("b_first_ovf", ovf_b, 1);
        chk("b_first_dout", dout_b, 1);
        en_b = 1'b0;

        ones = 0;
        run_zero_table("init");
        en = 1'b1;
        repeat (986) tick();
        chk_rng("zero_ones_1000", ones, 498, 502);
        chk("zero_ovf", ovf, 0);

        // Pause stepping, load a new sample mid-gap, and check its first enabled effect.
        d_pre = m_dout;
        en = 1'b0;
        for (int g = 0; g < 20; g++) begin
            if_a.in_valid = (g == 5);
            if_a.in_data  = 10'sd300;
            tick();
            chk("gap_dout_frozen", dout, d_pre);
        end
        if_a.in_valid = 1'b0;
        i1_pre = m_i1;
        fb_pre = m_dout ? FB : -FB;
        en = 1'b1;
        tick();
        chk("gap_resume_i1", dut_a.u_i1.q, i1_pre + 300 - fb_pre);

        for (int k = 0; k < 2; k++) begin
            if_a.in_valid = 1'b1;
            if_a.in_data  = (k == 0) ? 10'sd256 : -10'sd256;
            tick();
            if_a.in_valid = 1'b0;
            ones = 0;
            repeat (4000) tick();
            if (k == 0) chk_rng("dc_pos_ones", ones, 2992, 3008);
            else        chk_rng("dc_neg_ones", ones, 992, 1008);
            chk("dc_ovf", ovf, 0);
        end

        run_sine(511.0, -256, 1'b1);
        en = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("sine_ovf_clr", ovf, 0);
        ovf_clr = 1'b0;

        run_sine(486.4, 0, 1'b0);
        en = 1'b0; ovf_clr = 1'b1;
        tick();
        chk("sine95_ovf_clr", ovf, 0);
        ovf_clr = 1'b0;

        for (int r = 0; r < 3000; r++) begin
            int rd;
            rd            = int'($urandom_range(0, 800)) - 400;
            if_a.in_valid = ($urandom_range(0, 1) == 1);
            if_a.in_data  = rd[9:0];
            en            = ($urandom_range(0, 3) != 0);
            ovf_clr       = ($urandom_range(0, 15) == 0);
            tick();
        end
        if_a.in_valid = 1'b0; ovf_clr = 1'b0; en = 1'b1;
        repeat (3) tick();

        // Asynchronous reset between edges must clear outputs before the next edge.
        chk("b_ovf_sticky", ovf_b, 1);
        #20;
        rst_n = 1'b0;
        #5;
        chk("arst_dout", dout, 0);
        chk("arst_dout_n", dout_n, 1);
        chk("arst_ovf", ovf, 0);
        chk("arst_i1", dut_a.u_i1.q, 0);
        chk("arst_b_dout", dout_b, 0);
        chk("arst_b_dout_n", dout_n_b, 1);
        chk("arst_b_ovf", ovf_b, 0);
        model_reset();
        @(posedge clk);
        #30;
        rst_n = 1'b1;
        run_zero_table("rerun");

        // Clamp and clear on the same edge: set wins; then a clear with en low.
        en = 1'b0;
        en_b = 1'b1; clr_b = 1'b1;
        tick();
        chk("b_set_wins_ovf", ovf_b, 1);
        chk("b_set_wins_dout", dout_b, 1);
        en_b = 1'b0;
        tick();
        chk("b_clr_ovf", ovf_b, 0);
        clr_b = 1'b0;
        tick();
        chk("b_clr_hold", ovf_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
